// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter: shares the register-file write port between ALU and load
// writeback, load-first with ALU aging. Rev 1.0
// ============================================================================
module rf_wb_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [AW-1:0]     s0_addr,
  input  logic [DW-1:0]     s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [AW-1:0]     s1_addr,
  input  logic [DW-1:0]     s1_data,
  output logic              wb_we,
  output logic [AW-1:0]     wb_addr,
  output logic [DW-1:0]     wb_data,
  output logic [2**AW-1:0]  pend,
  output logic              starve_evt
);

  localparam int         C_NREG      = 2**AW;
  localparam logic [3:0] C_WAIT_LAST = 4'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    PRIO_LOAD = 1'b0,
    PRIO_ALU  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_starve;
  logic            w_xfer;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic            r_wb_we;
  logic [AW-1:0]   r_wb_addr;
  logic [DW-1:0]   r_wb_data;

  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_starve    = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (reset_n) begin
      case (r_state)
        PRIO_LOAD: begin
          w_grant1 = s1_valid;
          w_grant0 = s0_valid && !s1_valid;
          if (s0_valid && !w_grant0) begin
            // Stalled once more at the limit: promote the ALU for next cycle.
            if (r_cnt == C_WAIT_LAST) begin
              w_state_nxt = PRIO_ALU;
              w_cnt_nxt   = 4'd0;
              w_starve    = 1'b1;
            end else if (r_cnt != 4'hF) begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_cnt_nxt = 4'd0;
          end
        end
        PRIO_ALU: begin
          w_grant0  = s0_valid;
          w_grant1  = s1_valid && !s0_valid;
          w_cnt_nxt = 4'd0;
          if (w_grant0) begin
            w_state_nxt = PRIO_LOAD;
          end
        end
        default: begin
          w_state_nxt = PRIO_LOAD;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign w_xfer = w_grant0 || w_grant1;
  assign w_addr = w_grant0 ? s0_addr : s1_addr;
  assign w_data = w_grant0 ? s0_data : s1_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= PRIO_LOAD;
      r_cnt     <= 4'd0;
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Writes to x0 are accepted but never reach the register file.
      if (w_xfer && (w_addr != '0)) begin
        r_wb_we   <= 1'b1;
        r_wb_addr <= w_addr;
        r_wb_data <= w_data;
      end else begin
        r_wb_we <= 1'b0;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 1; i < C_NREG; i++) begin
      pend[i] = (s0_valid && (s0_addr == AW'(i))) ||
                (s1_valid && (s1_addr == AW'(i))) ||
                (r_wb_we  && (r_wb_addr == AW'(i)));
    end
  end

  assign s0_ready   = w_grant0;
  assign s1_ready   = w_grant1;
  assign starve_evt = w_starve;
  assign wb_we      = r_wb_we;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_arbiter: randomized and directed scoreboard bench for rf_wb_arbiter.
// Rev 1.0
// ============================================================================
module tb_rf_wb_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int MW   = 4;
  localparam int NREG = 2**AW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            s0_valid, s0_ready, s1_valid, s1_ready;
  logic [AW-1:0]   s0_addr, s1_addr, wb_addr;
  logic [DW-1:0]   s0_data, s1_data, wb_data;
  logic            wb_we, starve_evt;
  logic [NREG-1:0] pend;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend(pend), .starve_evt(starve_evt)
  );

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  bit            armed = 1'b0;
  wr_t           sbq[$];
  logic [DW-1:0] ref_rf[NREG];
  logic [DW-1:0] dut_rf[NREG];

  // Reference model state: promotion flag, wait count, expected write stage
  bit            promoted = 1'b0;
  int            waitc = 0;
  bit            mwe = 1'b0;
  logic [AW-1:0] maddr = '0;
  bit            g0_m = 1'b0, g1_m = 1'b0;
  bit            dg0 = 1'b0, dg1 = 1'b0;
  int            dut_starve = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: expected grants/pend/starve for this cycle, then advance to next
  always @(negedge clk) begin
    bit              e0, e1, es;
    logic [NREG-1:0] ep;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    if (armed) begin
      if (!reset_n) begin
        e0 = 0; e1 = 0; es = 0;
      end else if (promoted) begin
        e0 = s0_valid; e1 = s1_valid && !s0_valid; es = 0;
      end else begin
        e1 = s1_valid; e0 = s0_valid && !s1_valid;
        es = s0_valid && !e0 && (waitc == MW - 1);
      end
      ep = '0;
      for (int i = 1; i < NREG; i++)
        ep[i] = (s0_valid && s0_addr == i) || (s1_valid && s1_addr == i) || (mwe && maddr == i);
      chk("s0_ready", s0_ready, e0);
      chk("s1_ready", s1_ready, e1);
      chk("starve_evt", starve_evt, es);
      chk("pend", pend, ep);
      g0_m = e0; g1_m = e1;
      dg0 = s0_ready; dg1 = s1_ready;
      if (starve_evt) dut_starve++;
      if (!reset_n) begin
        promoted = 0; waitc = 0; mwe = 0; maddr = '0;
      end else begin
        mwe = 0;
        if (e0 || e1) begin
          a = e0 ? s0_addr : s1_addr;
          d = e0 ? s0_data : s1_data;
          if (a != 0) begin
            mwe = 1; maddr = a;
            sbq.push_back('{cyc + 1, a, d});
            ref_rf[a] = d;
          end
        end
        if (promoted) begin
          if (e0) promoted = 0;
          waitc = 0;
        end else if (s0_valid && !e0) begin
          if (waitc == MW - 1) begin promoted = 1; waitc = 0; end
          else if (waitc < 15) waitc++;
        end else begin
          waitc = 0;
        end
      end
    end
  end

  // Monitor: every presented write must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (armed) begin
      if (wb_we === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got write a=%0d d=%0h expected no write (cycle %0d)", wb_addr, wb_data, cyc);
        end else begin
          e = sbq.pop_front();
          chk("wb_cycle", 64'(cyc), 64'(e.c));
          chk("wb_addr", wb_addr, e.a);
          chk("wb_data", wb_data, e.d);
        end
        dut_rf[wb_addr] = wb_data;
      end else if (sbq.size() > 0 && sbq[0].c <= cyc) begin
        checks++; errors++;
        $display("FAIL wb_missing: got wb_we=%b expected write a=%0d d=%0h (cycle %0d)", wb_we, sbq[0].a, sbq[0].d, cyc);
        void'(sbq.pop_front());
      end
    end
  end

  // Requests must stay stable while stalled outside reset
  logic          p_rst, p0v, p0r, p1v, p1r;
  logic [AW-1:0] pa0, pa1;
  logic [DW-1:0] pd0, pd1;
  always @(negedge clk) begin
    if (armed && p_rst && reset_n) begin
      if (p0v && !p0r)
        assert (s0_valid && s0_addr == pa0 && s0_data == pd0) else $error("s0 request changed while stalled");
      if (p1v && !p1r)
        assert (s1_valid && s1_addr == pa1 && s1_data == pd1) else $error("s1 request changed while stalled");
    end
    p_rst = reset_n; p0v = s0_valid; p0r = s0_ready; pa0 = s0_addr; pd0 = s0_data;
    p1v = s1_valid; p1r = s1_ready; pa1 = s1_addr; pd1 = s1_data;
  end

  task automatic cycle_();
    @(posedge clk); #1;
  endtask

  task automatic send0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    s0_valid = 1; s0_addr = a; s0_data = d;
    do begin cycle_(); n++; end while (!g0_m && n < 100);
    if (!g0_m) begin checks++; errors++; $display("FAIL s0_timeout: got no grant expected grant within 100 cycles"); end
    s0_valid = 0;
  endtask

  task automatic send1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    s1_valid = 1; s1_addr = a; s1_data = d;
    do begin cycle_(); n++; end while (!g1_m && n < 100);
    if (!g1_m) begin checks++; errors++; $display("FAIL s1_timeout: got no grant expected grant within 100 cycles"); end
    s1_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, res, st0;
    bit done0;
    for (int i = 0; i < NREG; i++) begin ref_rf[i] = '0; dut_rf[i] = '0; end
    // Reset with both requesters valid
    reset_n = 0;
    s0_valid = 1; s0_addr = 3; s0_data = 32'h11;
    s1_valid = 1; s1_addr = 4; s1_data = 32'h22;
    @(posedge clk); #1 armed = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_pend", pend, 32'h18);
    cycle_();
    reset_n = 1; s0_valid = 0; s1_valid = 0;
    cycle_();

    // Single ALU write
    send0(5, 32'hDEADBEEF);
    @(negedge clk);
    chk("alu_pend5_t1", pend[5], 1);
    chk("alu_wb_data", wb_data, 32'hDEADBEEF);
    cycle_();
    @(negedge clk);
    chk("alu_pend5_t2", pend[5], 0);
    cycle_();

    // Aging: continuous loads against one ALU request
    n1 = 0; res = 0; done0 = 0; st0 = dut_starve;
    s1_valid = 1; s1_addr = 1; s1_data = 32'h100;
    s0_valid = 1; s0_addr = 7; s0_data = 32'h700;
    for (int k = 0; k < 40 && !(done0 && res >= 2); k++) begin
      cycle_();
      if (dg0) begin done0 = 1; s0_valid = 0; end
      if (g1_m) begin s1_addr = s1_addr + 1; s1_data = s1_data + 1; end
      if (dg1) begin if (done0) res++; else n1++; end
    end
    s1_valid = 0;
    chk("aging_load_wins", 64'(n1), 4);
    chk("aging_alu_granted", done0, 1);
    chk("aging_starve_pulses", 64'(dut_starve - st0), 1);
    chk("aging_load_resumes", res >= 2, 1);
    cycle_();

    // x0 write is accepted but dropped
    send1(0, 32'h1234);
    @(negedge clk);
    chk("x0_wb_we", wb_we, 0);
    cycle_();

    // Same destination from both requesters
    fork
      send0(9, 32'hA);
      send1(9, 32'hB);
    join
    repeat (3) cycle_();
    chk("same_addr_final", dut_rf[9], 32'hA);

    // Reset right after a transfer
    s0_valid = 1; s0_addr = 12; s0_data = 32'hC0FFEE;
    cycle_();
    s0_valid = 0; reset_n = 0;
    @(negedge clk);
    chk("midrst_wb_before", wb_we, 1);
    cycle_();
    @(negedge clk);
    chk("midrst_wb_after", wb_we, 0);
    cycle_();
    reset_n = 1;

    // Randomized traffic with occasional resets
    s0_valid = 0; s1_valid = 0;
    for (int k = 0; k < 3000; k++) begin
      cycle_();
      reset_n = ($urandom_range(0, 249) != 0);
      if (!s0_valid || g0_m) begin
        s0_valid = ($urandom_range(0, 99) < 60);
        s0_addr = AW'($urandom_range(0, 15));
        s0_data = $urandom;
      end
      if (!s1_valid || g1_m) begin
        s1_valid = ($urandom_range(0, 99) < (k < 1500 ? 85 : 40));
        s1_addr = AW'($urandom_range(0, 15));
        s1_data = $urandom;
      end
    end
    reset_n = 1;
    do cycle_(); while (s0_valid && !g0_m);
    s0_valid = 0;
    do cycle_(); while (s1_valid && !g1_m);
    s1_valid = 0;
    repeat (4) cycle_();
    chk("sb_drained", 64'(sbq.size()), 0);
    for (int i = 1; i < 16; i++) chk($sformatf("rf_%0d", i), dut_rf[i], ref_rf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
